mem_stage_lsu: RTL and testbench
================================

// Module: mem_stage_lsu
// PURPOSE
//  MEM-stage load/store unit. Consumes the EX->MEM control word (MemWriteM, ResultSrcM) plus address/data.
//  Drives a valid/ready data-memory request port and stalls the pipeline until the access completes.
//  Formats load data (sign/zero extension) for the MEM->WB register. Flags bus timeouts.
// PARAMETERS
//  XLEN            32   datapath width; only 32 is supported
//  TIMEOUT_CYCLES  255  max cycles spent in REQ+WAIT before abort; 0 = timeout disabled
// PORTS
//  clk             in   1     clock
//  rst             in   1     async reset, active-high
//  MemWriteM       in   1     store in MEM stage
//  ResultSrcM      in   2     2'b01 = load in MEM stage; other codes = no load
//  ALUResultM      in   32    effective byte address
//  WriteDataM      in   32    store data (rs2)
//  funct3M         in   3     access size/sign (RV32I encoding)
//  LsuStallM       out  1     hold IF..MEM stages; combinational
//  ReadDataM       out  32    formatted load data; registered
//  LsuErrM         out  1     one-cycle pulse: timeout or misaligned-trap abort
//  dmem_req_valid  out  1     request valid
//  dmem_req_ready  in   1     memory accepts request
//  dmem_we         out  1     1 = write
//  dmem_addr       out  32    {ALUResultM[31:2],2'b00}
//  dmem_wdata      out  32    store data lane-replicated
//  dmem_be         out  4     byte enables (writes only; 4'b0000 on reads)
//  dmem_rsp_valid  in   1     read data valid
//  dmem_rdata      in   32    read data word
// BEHAVIOUR
//  - Reset (asynchronous, active-high): state=IDLE, timeout counter=0, ReadDataM=0, LsuErrM=0; all dmem_* outputs 0.
//  - access = MemWriteM | (ResultSrcM==2'b01). MemWriteM has priority if both are set (treated as a store).
//  - FSM states:
//    IDLE: access -> REQ. LsuStallM = access.
//    REQ:  dmem_req_valid=1, LsuStallM=1. On handshake (valid&ready): store -> DONE; load -> WAIT.
//    WAIT: LsuStallM=1. On dmem_rsp_valid: ReadDataM <= fmt(dmem_rdata); -> DONE.
//    DONE: LsuStallM=0 for exactly one cycle so EX/MEM advances; -> IDLE.
//  - A new access detected in IDLE the cycle after DONE is a fresh instruction; no back-to-back merging.
//  - dmem_addr, dmem_we, dmem_wdata and dmem_be are held stable for the whole of REQ (taken from *M inputs, which the stall freezes).
//  - Store lanes by funct3[1:0]:
//    00 -> be = 4'b0001<<addr[1:0], wdata = {4{wd[7:0]}}
//    01 -> be = 4'b0011<<{addr[1],1'b0}, wdata = {2{wd[15:0]}}
//    10/11 -> be = 4'b1111, wdata = wd
//  - Load format, byte/half lane selected by addr[1:0] / addr[1]:
//    000 LB sign-extend; 001 LH sign-extend; 100 LBU zero-extend; 101 LHU zero-extend; all other codes -> LW.
//  - Non-load accesses leave ReadDataM unchanged.
//  - Timeout (TIMEOUT_CYCLES>0): counter clears on entry to REQ and increments each cycle in REQ/WAIT. At
//    count==TIMEOUT_CYCLES-1 with no completion -> DONE, LsuErrM=1 in the DONE cycle, ReadDataM<=0 for loads.
//    Completion in that same cycle wins over the timeout.
//  - dmem_rsp_valid outside WAIT is ignored. A response never completes in the same cycle as its request handshake.
//  - Reset asserted mid-access: FSM returns to IDLE immediately; the outstanding response is dropped.
// CONFIGURATION
//  LSU_MISALIGN_TRAP_EN defined:
//    - Misaligned accesses (half with addr[0]=1; word with addr[1:0]!=0) issue no request: IDLE -> DONE.
//    - LsuErrM=1 in that DONE cycle; ReadDataM is unchanged.
//  LSU_MISALIGN_TRAP_EN undefined:
//    - Misalignment is not checked. Half accesses ignore addr[0] and word accesses ignore addr[1:0];
//      the request proceeds normally.
// TESTING
//  1. SW addr 0x100, data 0xDEADBEEF, ready=1 -> req 1 cycle after detect: be=1111, we=1; LsuStallM high 2 cycles, then low 1 cycle.
//  2. LB addr 0x203, rdata 0x80112233, rsp 1 cycle after handshake -> ReadDataM=0xFFFFFF80; LBU same -> 0x00000080.
//  3. SH addr 0x002, data 0x0000ABCD -> be=1100, wdata=0xABCDABCD; LHU addr 0x002, rdata 0xBEEF0000 -> ReadDataM=0x0000BEEF.
//  4. TIMEOUT_CYCLES=4, ready held 0 -> DONE after 4 REQ cycles, LsuErrM pulse 1 cycle, no further req_valid.
//  5. Load in WAIT, rst pulsed -> all outputs 0, state IDLE; a late rsp_valid is ignored and ReadDataM stays 0.
//  6. LW addr 0x102: with LSU_MISALIGN_TRAP_EN -> no req_valid, LsuErrM=1;
//     without -> dmem_addr=0x100, normal load.

Source files
------------

// File: rtl/mem_stage_lsu_if.sv
// ----------------------------------------------------------------------------
// mem_stage_lsu_if
//   Data-memory request/response bus between the MEM-stage LSU (master) and
//   the data memory or bus bridge (slave).
//
//   req_valid  master -> slave  request valid
//   req_ready  slave  -> master request accepted
//   we         master -> slave  1 = write, 0 = read
//   addr       master -> slave  word-aligned byte address
//   wdata      master -> slave  lane-replicated store data
//   be         master -> slave  byte enables (writes only)
//   rsp_valid  slave  -> master read data valid
//   rdata      slave  -> master read data word
// ----------------------------------------------------------------------------
interface mem_stage_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        rsp_valid;
    logic [31:0] rdata;

    modport master (
        output req_valid, we, addr, wdata, be,
        input  req_ready, rsp_valid, rdata
    );

    modport slave (
        input  req_valid, we, addr, wdata, be,
        output req_ready, rsp_valid, rdata
    );
endinterface

// File: rtl/mem_stage_lsu.sv
// ----------------------------------------------------------------------------
// mem_stage_lsu
//   MEM-stage load/store unit. Turns the EX->MEM control word into a single
//   valid/ready data-memory transaction, stalls the front of the pipeline
//   until the access completes, and formats load data for MEM->WB.
//
//   Parameters
//     XLEN            datapath width (only 32 is supported)
//     TIMEOUT_CYCLES  max cycles spent in REQ+WAIT before abort; 0 disables
//
//   Ports
//     clk, rst        clock, asynchronous active-high reset
//     MemWriteM       store in MEM stage (wins over a simultaneous load)
//     ResultSrcM      2'b01 marks a load
//     ALUResultM      effective byte address
//     WriteDataM      store data
//     funct3M         RV32I access size/sign
//     LsuStallM       combinational stall for IF..MEM
//     ReadDataM       registered, formatted load data
//     LsuErrM         one-cycle pulse on timeout / misalignment abort
//     dmem            mem_stage_lsu_if.master data-memory bus
//
//   Build option
//     LSU_MISALIGN_TRAP_EN  when defined, misaligned half/word accesses are
//                           aborted without a bus request and flag LsuErrM.
//                           When undefined, low address bits are ignored.
// ----------------------------------------------------------------------------
module mem_stage_lsu #(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            MemWriteM,
    input  logic [1:0]      ResultSrcM,
    input  logic [XLEN-1:0] ALUResultM,
    input  logic [XLEN-1:0] WriteDataM,
    input  logic [2:0]      funct3M,
    output logic            LsuStallM,
    output logic [XLEN-1:0] ReadDataM,
    output logic            LsuErrM,
    mem_stage_lsu_if.master dmem
);

    // Counter only needs to reach TIMEOUT_CYCLES-1.
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state, next_state;
    logic [CNT_W-1:0]   cnt;
    logic               is_store, is_load, access;
    logic               handshake, timeout_hit, misaligned;
    logic               timeout_abort, misalign_abort;
    logic [3:0]         store_be;
    logic [31:0]        store_wdata;
    logic [31:0]        load_fmt;

    // Byte enables for a store of the given size at the given lane.
    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] a);
        logic [3:0] be;
        case (size)
            2'b00:   be = 4'b0001 << a;
            2'b01:   be = 4'b0011 << {a[1], 1'b0};
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate store data across all lanes so any enabled lane sees it.
    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] wd);
        logic [31:0] w;
        case (size)
            2'b00:   w = {4{wd[7:0]}};
            2'b01:   w = {2{wd[15:0]}};
            default: w = wd;
        endcase
        return w;
    endfunction

    // Extract the addressed byte/half and extend it; unknown codes act as LW.
    function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [1:0] a,
                                             input logic [31:0] w);
        logic signed [7:0]  sb;
        logic signed [15:0] sh;
        logic signed [31:0] r;
        sb = w[{a, 3'b000} +: 8];
        sh = w[{a[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  r = 32'(sb);
            3'b001:  r = 32'(sh);
            3'b100:  r = {24'd0, sb};
            3'b101:  r = {16'd0, sh};
            default: r = w;
        endcase
        return r;
    endfunction

    assign is_store  = MemWriteM;
    assign is_load   = !MemWriteM && (ResultSrcM == 2'b01);
    assign access    = is_store || is_load;
    assign handshake = (state == REQ) && dmem.req_ready;

    assign timeout_hit = (TIMEOUT_CYCLES > 0) && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

`ifdef LSU_MISALIGN_TRAP_EN
    assign misaligned = ((funct3M[1:0] == 2'b01) && ALUResultM[0]) ||
                        (funct3M[1] && (ALUResultM[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    assign store_be    = lane_be(funct3M[1:0], ALUResultM[1:0]);
    assign store_wdata = lane_wdata(funct3M[1:0], WriteDataM[31:0]);
    assign load_fmt    = fmt_load(funct3M, ALUResultM[1:0], dmem.rdata);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; a completion in the timeout cycle takes precedence.
    always_comb begin
        next_state     = state;
        timeout_abort  = 1'b0;
        misalign_abort = 1'b0;
        case (state)
            IDLE: begin
                if (access) begin
                    if (misaligned) begin
                        next_state     = DONE;
                        misalign_abort = 1'b1;
                    end else begin
                        next_state = REQ;
                    end
                end
            end
            REQ: begin
                if (handshake) begin
                    next_state = is_store ? DONE : WAIT;
                end else if (timeout_hit) begin
                    next_state    = DONE;
                    timeout_abort = 1'b1;
                end
            end
            WAIT: begin
                if (dmem.rsp_valid) begin
                    next_state = DONE;
                end else if (timeout_hit) begin
                    next_state    = DONE;
                    timeout_abort = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Outputs: bus fields come straight from the stall-frozen *M inputs in REQ.
    always_comb begin
        LsuStallM      = 1'b0;
        dmem.req_valid = 1'b0;
        dmem.we        = 1'b0;
        dmem.addr      = 32'd0;
        dmem.wdata     = 32'd0;
        dmem.be        = 4'b0000;
        case (state)
            IDLE: LsuStallM = access;
            REQ: begin
                LsuStallM      = 1'b1;
                dmem.req_valid = 1'b1;
                dmem.we        = is_store;
                dmem.addr      = {ALUResultM[31:2], 2'b00};
                if (is_store) begin
                    dmem.wdata = store_wdata;
                    dmem.be    = store_be;
                end
            end
            WAIT:    LsuStallM = 1'b1;
            default: LsuStallM = 1'b0;
        endcase
    end

    // Timeout counter, load result and error pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            ReadDataM <= '0;
            LsuErrM   <= 1'b0;
        end else begin
            LsuErrM <= timeout_abort || misalign_abort;

            if (state == IDLE && next_state == REQ) begin
                cnt <= '0;
            end else if (state == REQ || state == WAIT) begin
                cnt <= cnt + CNT_W'(1);
            end

            if (state == WAIT && dmem.rsp_valid) begin
                ReadDataM <= load_fmt;
            end else if (timeout_abort && is_load) begin
                ReadDataM <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [2:0]  funct3M;
    logic        LsuStallM;
    logic [31:0] ReadDataM;
    logic        LsuErrM;

    int errors = 0;
    int checks = 0;

    mem_stage_lsu_if dmem ();

    mem_stage_lsu #(
        .XLEN           (32),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .MemWriteM  (MemWriteM),
        .ResultSrcM (ResultSrcM),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .funct3M    (funct3M),
        .LsuStallM  (LsuStallM),
        .ReadDataM  (ReadDataM),
        .LsuErrM    (LsuErrM),
        .dmem       (dmem)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        MemWriteM  = 1'b0;
        ResultSrcM = 2'b00;
        ALUResultM = 32'd0;
        WriteDataM = 32'd0;
        funct3M    = 3'b000;
    endtask

    // Runs one access with ready=1 and, for loads, a response one cycle after
    // the handshake. Entered and left at a negedge with the DUT idle.
    task automatic run_access(input string tag, input logic st, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] rd, input logic [31:0] exp_addr,
                              input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                              input logic [31:0] exp_rd);
        MemWriteM         = st;
        ResultSrcM        = st ? 2'b00 : 2'b01;
        funct3M           = f3;
        ALUResultM        = a;
        WriteDataM        = wd;
        dmem.req_ready    = 1'b1;
        #1;
        chk({tag, ".stall_detect"}, 32'(LsuStallM), 32'd1);
        chk({tag, ".novalid_detect"}, 32'(dmem.req_valid), 32'd0);
        @(negedge clk);
        chk({tag, ".req_valid"}, 32'(dmem.req_valid), 32'd1);
        chk({tag, ".we"}, 32'(dmem.we), 32'(st));
        chk({tag, ".addr"}, dmem.addr, exp_addr);
        chk({tag, ".be"}, 32'(dmem.be), 32'(exp_be));
        if (st) chk({tag, ".wdata"}, dmem.wdata, exp_wdata);
        if (!st) begin
            @(negedge clk);
            chk({tag, ".stall_wait"}, 32'(LsuStallM), 32'd1);
            chk({tag, ".novalid_wait"}, 32'(dmem.req_valid), 32'd0);
            dmem.rsp_valid = 1'b1;
            dmem.rdata     = rd;
        end
        @(negedge clk);
        chk({tag, ".stall_done"}, 32'(LsuStallM), 32'd0);
        chk({tag, ".err_done"}, 32'(LsuErrM), 32'd0);
        if (!st) chk({tag, ".rdata"}, ReadDataM, exp_rd);
        dmem.rsp_valid = 1'b0;
        idle_inputs();
        @(negedge clk);
        chk({tag, ".stall_idle"}, 32'(LsuStallM), 32'd0);
    endtask

    initial begin
        rst            = 1'b1;
        idle_inputs();
        dmem.req_ready = 1'b0;
        dmem.rsp_valid = 1'b0;
        dmem.rdata     = 32'd0;

        @(negedge clk);
        @(negedge clk);
        chk("rst.stall", 32'(LsuStallM), 32'd0);
        chk("rst.rdata", ReadDataM, 32'd0);
        chk("rst.err", 32'(LsuErrM), 32'd0);
        chk("rst.req_valid", 32'(dmem.req_valid), 32'd0);
        chk("rst.we", 32'(dmem.we), 32'd0);
        chk("rst.addr", dmem.addr, 32'd0);
        chk("rst.be", 32'(dmem.be), 32'd0);
        chk("rst.wdata", dmem.wdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Stores and loads of every size/lane flavour
        run_access("sw",  1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'd0,
                   32'h0000_0100, 4'b1111, 32'hDEAD_BEEF, 32'd0);
        run_access("lb",  1'b0, 3'b000, 32'h0000_0203, 32'd0, 32'h8011_2233,
                   32'h0000_0200, 4'b0000, 32'd0, 32'hFFFF_FF80);
        run_access("lbu", 1'b0, 3'b100, 32'h0000_0203, 32'd0, 32'h8011_2233,
                   32'h0000_0200, 4'b0000, 32'd0, 32'h0000_0080);
        run_access("sh",  1'b1, 3'b001, 32'h0000_0002, 32'h0000_ABCD, 32'd0,
                   32'h0000_0000, 4'b1100, 32'hABCD_ABCD, 32'd0);
        run_access("sb",  1'b1, 3'b000, 32'h0000_0001, 32'h0000_00A5, 32'd0,
                   32'h0000_0000, 4'b0010, 32'hA5A5_A5A5, 32'd0);
        run_access("lh",  1'b0, 3'b001, 32'h0000_0000, 32'd0, 32'h1234_F00D,
                   32'h0000_0000, 4'b0000, 32'd0, 32'hFFFF_F00D);
        run_access("lhu", 1'b0, 3'b101, 32'h0000_0002, 32'd0, 32'hBEEF_0000,
                   32'h0000_0000, 4'b0000, 32'd0, 32'h0000_BEEF);

        // Misaligned word load
`ifdef LSU_MISALIGN_TRAP_EN
        MemWriteM      = 1'b0;
        ResultSrcM     = 2'b01;
        funct3M        = 3'b010;
        ALUResultM     = 32'h0000_0102;
        dmem.req_ready = 1'b1;
        #1;
        chk("mis.stall_detect", 32'(LsuStallM), 32'd1);
        @(negedge clk);
        chk("mis.no_req", 32'(dmem.req_valid), 32'd0);
        chk("mis.err", 32'(LsuErrM), 32'd1);
        chk("mis.stall_done", 32'(LsuStallM), 32'd0);
        chk("mis.rdata_kept", ReadDataM, 32'h0000_BEEF);
        idle_inputs();
        @(negedge clk);
        chk("mis.err_pulse", 32'(LsuErrM), 32'd0);
        chk("mis.no_req_after", 32'(dmem.req_valid), 32'd0);
`else
        run_access("lw_mis", 1'b0, 3'b010, 32'h0000_0102, 32'd0, 32'hCAFE_F00D,
                   32'h0000_0100, 4'b0000, 32'd0, 32'hCAFE_F00D);
`endif

        // Reset while a load waits for its response
        MemWriteM      = 1'b0;
        ResultSrcM     = 2'b01;
        funct3M        = 3'b010;
        ALUResultM     = 32'h0000_0400;
        dmem.req_ready = 1'b1;
        @(negedge clk);
        chk("rstmid.req_valid", 32'(dmem.req_valid), 32'd1);
        @(negedge clk);
        chk("rstmid.stall_wait", 32'(LsuStallM), 32'd1);
        rst = 1'b1;
        idle_inputs();
        #1;
        chk("rstmid.rdata", ReadDataM, 32'd0);
        chk("rstmid.stall", 32'(LsuStallM), 32'd0);
        chk("rstmid.req_valid0", 32'(dmem.req_valid), 32'd0);
        chk("rstmid.err", 32'(LsuErrM), 32'd0);
        @(negedge clk);
        rst            = 1'b0;
        dmem.rsp_valid = 1'b1;
        dmem.rdata     = 32'h1234_5678;
        @(negedge clk);
        chk("rstmid.late_rsp", ReadDataM, 32'd0);
        chk("rstmid.late_stall", 32'(LsuStallM), 32'd0);
        chk("rstmid.late_req", 32'(dmem.req_valid), 32'd0);
        dmem.rsp_valid = 1'b0;

        // Give ReadDataM a non-zero value so the timeout clear is visible
        run_access("lw", 1'b0, 3'b010, 32'h0000_0500, 32'd0, 32'h0BAD_CAFE,
                   32'h0000_0500, 4'b0000, 32'd0, 32'h0BAD_CAFE);

        // Timeout: ready held low, TIMEOUT_CYCLES=4
        dmem.req_ready = 1'b0;
        MemWriteM      = 1'b0;
        ResultSrcM     = 2'b01;
        funct3M        = 3'b010;
        ALUResultM     = 32'h0000_0300;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("tmo.req_valid%0d", i), 32'(dmem.req_valid), 32'd1);
            chk($sformatf("tmo.err_low%0d", i), 32'(LsuErrM), 32'd0);
        end
        @(negedge clk);
        chk("tmo.err", 32'(LsuErrM), 32'd1);
        chk("tmo.stall_done", 32'(LsuStallM), 32'd0);
        chk("tmo.no_req", 32'(dmem.req_valid), 32'd0);
        chk("tmo.rdata_clr", ReadDataM, 32'd0);
        idle_inputs();
        @(negedge clk);
        chk("tmo.err_pulse", 32'(LsuErrM), 32'd0);
        chk("tmo.no_req_after", 32'(dmem.req_valid), 32'd0);
        @(negedge clk);
        chk("tmo.no_req_after2", 32'(dmem.req_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
